relu_maxpool2d: RTL and testbench

Reads the conv feature-map buffer BRAM that the convolution layer writes. Applies ReLU and a POOL×POOL max-pool with stride POOL. Writes the pooled map to a pool-buffer BRAM. Sits between the conv layer and the dense layer; the top-level controller starts it after the conv layer's done.

---
 rtl/cnn_pkg.sv | 29 ++
 rtl/relu_maxpool2d.sv | 208 ++++++++++++++++++++
 tb/tb_relu_maxpool2d.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_pkg
// Purpose  : Shared sample type, range limits and addressing helpers for the
//            conv / pool / dense layers.
// Revision : 1.0
// ============================================================================
package cnn_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    localparam sample_t S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam sample_t S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    // Row-major linear index of (ch,row,col) in a CH x H x W buffer.
    function automatic int lin3(input int ch, input int row, input int col,
                                input int h, input int w);
        return (ch * h + row) * w + col;
    endfunction

    // Counter/address width that never collapses to zero bits.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/relu_maxpool2d.sv
`default_nettype none
// ============================================================================
// Module   : relu_maxpool2d
// Purpose  : ReLU + POOLxPOOL/stride-POOL max-pool from the conv buffer BRAM
//            into the pool buffer BRAM.
// Revision : 1.0
// ============================================================================
module relu_maxpool2d
    import cnn_pkg::*;
#(
    parameter int  DATA_WIDTH = 16,
    parameter int  CHANNELS   = 8,
    parameter int  IMG_SIZE   = 28,
    parameter int  POOL       = 2,
    localparam int OUT_SIZE   = IMG_SIZE / POOL,
    localparam int CONV_AW    = addr_w(CHANNELS * IMG_SIZE * IMG_SIZE),
    localparam int POOL_AW    = addr_w(CHANNELS * OUT_SIZE * OUT_SIZE)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    output logic [CONV_AW-1:0]           conv_addr,
    output logic                         conv_en,
    input  logic signed [DATA_WIDTH-1:0] conv_q,
    output logic [POOL_AW-1:0]           pool_addr,
    output logic                         pool_en,
    output logic                         pool_we,
    output logic signed [DATA_WIDTH-1:0] pool_d,
    output logic                         busy,
    output logic                         done
);

    localparam int CH_W  = addr_w(CHANNELS);
    localparam int PO_W  = addr_w(OUT_SIZE);
    localparam int WIN_W = addr_w(POOL);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ISSUE  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_CMP    = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;
    localparam logic [2:0] ST_FINISH = 3'd5;

    logic [2:0]                   state_q, state_d;
    logic [CH_W-1:0]              ch_q, ch_d;
    logic [PO_W-1:0]              prow_q, prow_d, pcol_q, pcol_d;
    logic [WIN_W-1:0]             wr_q, wr_d, wc_q, wc_d;
    logic signed [DATA_WIDTH-1:0] max_q, max_d;
    logic [CONV_AW-1:0]           conv_addr_q, conv_addr_d;
    logic                         conv_en_q, conv_en_d;
    logic [POOL_AW-1:0]           pool_addr_q, pool_addr_d;
    logic                         pool_en_q, pool_en_d;
    logic                         pool_we_q, pool_we_d;
    logic signed [DATA_WIDTH-1:0] pool_d_q, pool_d_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;

    logic                         w_win_last;
    logic                         w_map_last;
    logic signed [DATA_WIDTH-1:0] w_cand;

    assign w_win_last = (wr_q == WIN_W'(POOL - 1)) && (wc_q == WIN_W'(POOL - 1));
    assign w_map_last = (ch_q == CH_W'(CHANNELS - 1)) &&
                        (prow_q == PO_W'(OUT_SIZE - 1)) &&
                        (pcol_q == PO_W'(OUT_SIZE - 1));
    assign w_cand     = (conv_q > max_q) ? conv_q : max_q;

    // Strobes are registered on entry to the state that owns them, so they
    // are visible exactly while the FSM sits in WAIT / WRITE / FINISH.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        prow_d      = prow_q;
        pcol_d      = pcol_q;
        wr_d        = wr_q;
        wc_d        = wc_q;
        max_d       = max_q;
        conv_addr_d = conv_addr_q;
        conv_en_d   = 1'b0;
        pool_addr_d = pool_addr_q;
        pool_en_d   = 1'b0;
        pool_we_d   = 1'b0;
        pool_d_d    = pool_d_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ch_d    = '0;
                    prow_d  = '0;
                    pcol_d  = '0;
                    wr_d    = '0;
                    wc_d    = '0;
                    max_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                conv_addr_d = CONV_AW'(lin3(int'(ch_q),
                                            int'(prow_q) * POOL + int'(wr_q),
                                            int'(pcol_q) * POOL + int'(wc_q),
                                            IMG_SIZE, IMG_SIZE));
                conv_en_d   = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                state_d = ST_CMP;
            end
            ST_CMP: begin
                max_d = w_cand;
                if (w_win_last) begin
                    wr_d        = '0;
                    wc_d        = '0;
                    pool_d_d    = w_cand;
                    pool_en_d   = 1'b1;
                    pool_we_d   = 1'b1;
                    pool_addr_d = POOL_AW'(lin3(int'(ch_q), int'(prow_q), int'(pcol_q),
                                                OUT_SIZE, OUT_SIZE));
                    state_d     = ST_WRITE;
                end else begin
                    if (wc_q == WIN_W'(POOL - 1)) begin
                        wc_d = '0;
                        wr_d = wr_q + WIN_W'(1);
                    end else begin
                        wc_d = wc_q + WIN_W'(1);
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_WRITE: begin
                // Zero-seeded max is what makes the ReLU free.
                max_d = '0;
                if (w_map_last) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_ISSUE;
                    if (pcol_q == PO_W'(OUT_SIZE - 1)) begin
                        pcol_d = '0;
                        if (prow_q == PO_W'(OUT_SIZE - 1)) begin
                            prow_d = '0;
                            ch_d   = ch_q + CH_W'(1);
                        end else begin
                            prow_d = prow_q + PO_W'(1);
                        end
                    end else begin
                        pcol_d = pcol_q + PO_W'(1);
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            prow_q      <= '0;
            pcol_q      <= '0;
            wr_q        <= '0;
            wc_q        <= '0;
            max_q       <= '0;
            conv_addr_q <= '0;
            conv_en_q   <= 1'b0;
            pool_addr_q <= '0;
            pool_en_q   <= 1'b0;
            pool_we_q   <= 1'b0;
            pool_d_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            prow_q      <= prow_d;
            pcol_q      <= pcol_d;
            wr_q        <= wr_d;
            wc_q        <= wc_d;
            max_q       <= max_d;
            conv_addr_q <= conv_addr_d;
            conv_en_q   <= conv_en_d;
            pool_addr_q <= pool_addr_d;
            pool_en_q   <= pool_en_d;
            pool_we_q   <= pool_we_d;
            pool_d_q    <= pool_d_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign conv_addr = conv_addr_q;
    assign conv_en   = conv_en_q;
    assign pool_addr = pool_addr_q;
    assign pool_en   = pool_en_q;
    assign pool_we   = pool_we_q;
    assign pool_d    = pool_d_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_relu_maxpool2d.sv
`default_nettype none
// ============================================================================
// Module   : tb_relu_maxpool2d
// Purpose  : Self-checking bench for relu_maxpool2d (default, 2x2 and odd maps).
// Revision : 1.0
// ============================================================================
module tb_relu_maxpool2d;
    import cnn_pkg::*;

    localparam int DW    = 16;
    localparam int B_CH  = 8;
    localparam int B_IMG = 28;
    localparam int B_OUT = 14;
    localparam int B_N   = B_CH * B_OUT * B_OUT;
    localparam int O_CH  = 2;
    localparam int O_IMG = 5;
    localparam int O_OUT = 2;
    localparam int O_N   = O_CH * O_OUT * O_OUT;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   cyc     = 0;
    int   total   = 0;
    int   bad     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // default-size instance
    logic                 start_big = 1'b0;
    logic [12:0]          b_conv_addr;
    logic                 b_conv_en;
    logic signed [DW-1:0] b_conv_q = '0;
    logic [10:0]          b_pool_addr;
    logic                 b_pool_en, b_pool_we, b_busy, b_done;
    logic signed [DW-1:0] b_pool_d;
    logic signed [DW-1:0] mem_big [B_CH*B_IMG*B_IMG];
    int                   golden_big [B_N];

    // single-window instance
    logic                 start_one = 1'b0;
    logic [1:0]           n_conv_addr;
    logic                 n_conv_en;
    logic signed [DW-1:0] n_conv_q = '0;
    logic [0:0]           n_pool_addr;
    logic                 n_pool_en, n_pool_we, n_busy, n_done;
    logic signed [DW-1:0] n_pool_d;
    logic signed [DW-1:0] mem_one [4];

    // odd-size instance
    logic                 start_odd = 1'b0;
    logic [5:0]           o_conv_addr;
    logic                 o_conv_en;
    logic signed [DW-1:0] o_conv_q = '0;
    logic [2:0]           o_pool_addr;
    logic                 o_pool_en, o_pool_we, o_busy, o_done;
    logic signed [DW-1:0] o_pool_d;
    logic signed [DW-1:0] mem_odd [O_CH*O_IMG*O_IMG];
    int                   golden_odd [O_N];

    relu_maxpool2d u_big (
        .clk(clk), .reset_n(reset_n), .start(start_big),
        .conv_addr(b_conv_addr), .conv_en(b_conv_en), .conv_q(b_conv_q),
        .pool_addr(b_pool_addr), .pool_en(b_pool_en), .pool_we(b_pool_we),
        .pool_d(b_pool_d), .busy(b_busy), .done(b_done)
    );

    relu_maxpool2d #(.DATA_WIDTH(DW), .CHANNELS(1), .IMG_SIZE(2), .POOL(2)) u_one (
        .clk(clk), .reset_n(reset_n), .start(start_one),
        .conv_addr(n_conv_addr), .conv_en(n_conv_en), .conv_q(n_conv_q),
        .pool_addr(n_pool_addr), .pool_en(n_pool_en), .pool_we(n_pool_we),
        .pool_d(n_pool_d), .busy(n_busy), .done(n_done)
    );

    relu_maxpool2d #(.DATA_WIDTH(DW), .CHANNELS(O_CH), .IMG_SIZE(O_IMG), .POOL(2)) u_odd (
        .clk(clk), .reset_n(reset_n), .start(start_odd),
        .conv_addr(o_conv_addr), .conv_en(o_conv_en), .conv_q(o_conv_q),
        .pool_addr(o_pool_addr), .pool_en(o_pool_en), .pool_we(o_pool_we),
        .pool_d(o_pool_d), .busy(o_busy), .done(o_done)
    );

    // 1-cycle-latency BRAM read ports
    always @(posedge clk) if (b_conv_en) b_conv_q <= mem_big[int'(b_conv_addr)];
    always @(posedge clk) if (n_conv_en) n_conv_q <= mem_one[int'(n_conv_addr)];
    always @(posedge clk) if (o_conv_en) o_conv_q <= mem_odd[int'(o_conv_addr)];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitors ----------------
    int b_wcnt = 0, b_base = 0, b_rd_cnt = 0, b_done_cnt = 0;
    logic b_en_prev = 1'b0;
    always @(negedge clk) begin : mon_big
        int idx;
        if (b_conv_en) begin
            b_rd_cnt++;
            chk("big_conv_en_single_cycle", b_en_prev, 0);
        end
        b_en_prev = b_conv_en;
        if (b_done) b_done_cnt++;
        if (b_pool_en || b_pool_we) begin
            idx = b_wcnt - b_base;
            chk("big_pool_we", b_pool_we, 1);
            chk("big_pool_en_busy", b_busy, 1);
            chk("big_pool_addr", b_pool_addr, idx);
            if (idx < B_N) chk("big_pool_d", b_pool_d, golden_big[idx]);
            else           chk("big_extra_write", idx, B_N - 1);
            b_wcnt++;
        end
    end

    int n_wa[$], n_wd[$];
    int n_rd_cnt = 0, n_done_cnt = 0;
    always @(negedge clk) begin : mon_one
        if (n_conv_en) n_rd_cnt++;
        if (n_done) n_done_cnt++;
        if (n_pool_en || n_pool_we) begin
            chk("one_pool_we", n_pool_we, 1);
            n_wa.push_back(int'(n_pool_addr));
            n_wd.push_back(int'(n_pool_d));
        end
    end

    int o_wa[$], o_wd[$];
    int o_rd_cnt = 0, o_done_cnt = 0, o_edge_reads = 0;
    always @(negedge clk) begin : mon_odd
        int a;
        if (o_conv_en) begin
            o_rd_cnt++;
            a = int'(o_conv_addr);
            if (a / 25 >= O_CH || (a % 25) / 5 >= 4 || a % 5 >= 4) o_edge_reads++;
        end
        if (o_done) o_done_cnt++;
        if (o_pool_en || o_pool_we) begin
            chk("odd_pool_we", o_pool_we, 1);
            o_wa.push_back(int'(o_pool_addr));
            o_wd.push_back(int'(o_pool_d));
        end
    end

    // ---------------- helpers ----------------
    function automatic bit done_of(input int w);
        case (w)
            0:       return b_done;
            1:       return n_done;
            default: return o_done;
        endcase
    endfunction

    function automatic bit busy_of(input int w);
        case (w)
            0:       return b_busy;
            1:       return n_busy;
            default: return o_busy;
        endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            0:       start_big = v;
            1:       start_one = v;
            default: start_odd = v;
        endcase
    endtask

    // t0 is the cycle in which start is presented (counted as cycle 1).
    task automatic start_run(input int w, output int t0);
        @(negedge clk);
        set_start(w, 1'b1);
        t0 = cyc;
        @(negedge clk);
        set_start(w, 1'b0);
        chk("busy_after_start", busy_of(w), 1);
    endtask

    task automatic wait_done(input int w, input int t0, input int limit, input int poke,
                             input string tag, output int incl);
        incl = -1;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (w == 2) start_odd = (poke > 0) && (cyc - t0 + 1 == poke);
            if (done_of(w)) begin
                incl = cyc - t0 + 1;
                break;
            end
        end
        if (incl < 0) chk({tag, "_done_timeout"}, 0, 1);
    endtask

    task automatic run_one(input string tag, input int a, input int b, input int c,
                           input int d, input int exp);
        int t0, incl, w0, r0;
        mem_one[0] = DW'(a);
        mem_one[1] = DW'(b);
        mem_one[2] = DW'(c);
        mem_one[3] = DW'(d);
        w0 = n_wa.size();
        r0 = n_rd_cnt;
        start_run(1, t0);
        wait_done(1, t0, 100, 0, tag, incl);
        chk({tag, "_done_cycle"}, incl, 15);
        chk({tag, "_writes"}, n_wa.size() - w0, 1);
        if (n_wa.size() > w0) begin
            chk({tag, "_addr"}, n_wa[w0], 0);
            chk({tag, "_data"}, n_wd[w0], exp);
        end
        chk({tag, "_reads"}, n_rd_cnt - r0, 4);
    endtask

    task automatic check_odd(input int w0, input string tag);
        chk({tag, "_writes"}, o_wa.size() - w0, O_N);
        for (int i = 0; i < O_N; i++) begin
            if (w0 + i < o_wa.size()) begin
                chk({tag, "_addr"}, o_wa[w0 + i], i);
                chk({tag, "_data"}, o_wd[w0 + i], golden_odd[i]);
            end
        end
    endtask

    task automatic run_big(input string tag);
        int t0, incl, r0;
        b_base = b_wcnt;
        r0     = b_rd_cnt;
        start_run(0, t0);
        wait_done(0, t0, 21000, 0, tag, incl);
        chk({tag, "_done_cycle"}, incl, 20386);
        chk({tag, "_writes"}, b_wcnt - b_base, B_N);
        chk({tag, "_conv_en_pulses"}, b_rd_cnt - r0, 6272);
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int t0, t1, incl, w0, w1, d0, r0, dn0;
        int m, v;

        // golden maps: max(0, window max), windows in ch/prow/pcol order
        for (int i = 0; i < B_CH * B_IMG * B_IMG; i++) mem_big[i] = DW'(i % 97);
        for (int i = 0; i < O_CH * O_IMG * O_IMG; i++) mem_odd[i] = DW'((i * 37) % 101 - 50);
        for (int i = 0; i < 4; i++) mem_one[i] = '0;
        for (int ch = 0; ch < B_CH; ch++)
            for (int pr = 0; pr < B_OUT; pr++)
                for (int pc = 0; pc < B_OUT; pc++) begin
                    m = 0;
                    for (int k = 0; k < 4; k++) begin
                        v = int'(mem_big[(ch * B_IMG + pr * 2 + k / 2) * B_IMG + pc * 2 + k % 2]);
                        if (v > m) m = v;
                    end
                    golden_big[(ch * B_OUT + pr) * B_OUT + pc] = m;
                end
        for (int ch = 0; ch < O_CH; ch++)
            for (int pr = 0; pr < O_OUT; pr++)
                for (int pc = 0; pc < O_OUT; pc++) begin
                    m = 0;
                    for (int k = 0; k < 4; k++) begin
                        v = int'(mem_odd[(ch * O_IMG + pr * 2 + k / 2) * O_IMG + pc * 2 + k % 2]);
                        if (v > m) m = v;
                    end
                    golden_odd[(ch * O_OUT + pr) * O_OUT + pc] = m;
                end

        // hand-computed pins on the model
        chk("model_big_0", golden_big[0], 29);
        chk("model_big_1", golden_big[1], 31);
        chk("model_big_14", golden_big[14], 85);
        chk("model_big_last", golden_big[B_N - 1], 63);
        chk("model_odd_0", golden_odd[0], 34);
        chk("model_odd_7", golden_odd[7], 43);

        // asynchronous reset, checked before any clock edge
        #2 reset_n = 1'b0;
        #1 chk("reset_async_big_outs",
               {b_conv_addr, b_conv_en, b_pool_addr, b_pool_en, b_pool_we, b_pool_d, b_busy, b_done}, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_state_big",
            {b_conv_addr, b_conv_en, b_pool_addr, b_pool_en, b_pool_we, b_pool_d, b_busy, b_done}, 0);
        chk("reset_state_one", {n_conv_en, n_pool_en, n_pool_we, n_busy, n_done}, 0);
        chk("reset_state_odd", {o_conv_en, o_pool_en, o_pool_we, o_busy, o_done}, 0);

        // single window and ReLU clamp
        run_one("one_basic", 5, -3, 12, 7, 12);
        run_one("one_all_neg", -1, -200, -32768, -5, 0);
        run_one("one_mixed", -4, 0, -1, -9, 0);
        run_one("one_smax", -7, int'(S_MAX), 3, int'(S_MIN), 32767);

        // odd size, with a start pulse while busy that must be ignored
        w0  = o_wa.size();
        r0  = o_rd_cnt;
        dn0 = o_done_cnt;
        start_run(2, t0);
        wait_done(2, t0, 200, 30, "odd_run1", incl);
        chk("odd_run1_done_cycle", incl, 106);
        check_odd(w0, "odd_run1");
        chk("odd_run1_reads", o_rd_cnt - r0, 32);
        // start held through the done (FINISH) cycle, then kept one more cycle
        start_odd = 1'b1;
        @(negedge clk);
        chk("odd_start_in_finish_ignored", o_busy, 0);
        t1 = cyc;
        @(negedge clk);
        start_odd = 1'b0;
        chk("odd_start_after_done_accepted", o_busy, 1);
        w1 = o_wa.size();
        chk("odd_run1_no_extra_writes", w1 - w0, O_N);
        wait_done(2, t1, 200, 0, "odd_run2", incl);
        chk("odd_run2_done_cycle", incl, 106);
        check_odd(w1, "odd_run2");
        @(negedge clk);
        chk("odd_done_pulses", o_done_cnt - dn0, 2);
        chk("odd_no_edge_reads", o_edge_reads, 0);

        // full default map
        run_big("big_run");

        // reset in the 500th cycle of a default run
        b_base = b_wcnt;
        start_run(0, t0);
        while (cyc - t0 + 1 < 500) @(negedge clk);
        #1 reset_n = 1'b0;
        #1 chk("midrun_reset_async_outs",
               {b_conv_addr, b_conv_en, b_pool_addr, b_pool_en, b_pool_we, b_pool_d, b_busy, b_done}, 0);
        d0 = b_done_cnt;
        w0 = b_wcnt;
        r0 = b_rd_cnt;
        chk("midrun_partial_writes", w0 - b_base, 38);
        repeat (20) @(negedge clk);
        chk("midrun_no_done", b_done_cnt - d0, 0);
        chk("midrun_no_writes", b_wcnt - w0, 0);
        chk("midrun_no_reads", b_rd_cnt - r0, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrun_idle_after_release", {b_busy, b_conv_en, b_done}, 0);
        run_big("big_rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
